// File: rtl/audio_sd_dac_if.sv
// Sample stream into the DAC output stage: 16-bit signed PCM over valid/ready.
interface audio_sd_dac_if;
    logic [15:0] in_sample;
    logic        in_valid;
    logic        in_ready;

    modport master (
        output in_sample,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_sample,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/audio_sd_dac.sv
// Audio output stage: paced one-entry sample buffer, soft gain ramp on
// start/stop, and a first-order delta-sigma modulator driving a 1-bit pin.
module audio_sd_dac #(
    parameter int unsigned CLOCK_RATE  = 3_125_000,
    parameter int unsigned SAMPLE_RATE = 16_000,
    parameter int unsigned GAIN_MAX    = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    audio_sd_dac_if.slave        in_if,
    output logic                 sample_tick,
    output logic                 audio_out,
    output logic [1:0]           state,
    output logic [7:0]           gain,
    output logic [7:0]           underrun_count
);

    localparam int unsigned DIVIDER = CLOCK_RATE / SAMPLE_RATE;
    localparam int unsigned CW      = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(DIVIDER - 1);
    localparam logic [7:0]    GMAX      = 8'(GAIN_MAX);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_PLAY      = 2'd2,
        S_RAMP_DOWN = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      gain_q, gain_d;
    logic [CW-1:0]   cnt_q;
    logic [15:0]     hold_q;
    logic            hold_full_q;
    logic [15:0]     cur_sample_q;
    logic [7:0]      underrun_q;
    logic [15:0]     scaled_q;
    logic [15:0]     acc_q;
    logic            audio_q;

    logic            tick;
    logic            accept;
    logic            clr;
    logic signed [23:0] cur_ext;
    logic signed [23:0] gain_ext;
    logic signed [23:0] prod;
    logic [15:0]     u;
    logic [16:0]     sum;

    assign tick   = (state_q != S_IDLE) && (cnt_q == TICK_LAST);
    assign accept = in_if.in_valid && in_if.in_ready;
    // Buffer, underrun count and modulator are wiped on the cycle IDLE is entered.
    assign clr    = (state_d == S_IDLE);

    assign cur_ext  = {{8{cur_sample_q[15]}}, cur_sample_q};
    assign gain_ext = {16'd0, gain_q};
    assign prod     = cur_ext * gain_ext;
    assign u        = scaled_q ^ 16'h8000;
    assign sum      = {1'b0, acc_q} + {1'b0, u};

    assign in_if.in_ready = (state_q != S_IDLE) && !hold_full_q;
    assign sample_tick    = tick;
    assign audio_out      = audio_q;
    assign state          = state_q;
    assign gain           = gain_q;
    assign underrun_count = underrun_q;

    // Gain FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gain_q  <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
        end
    end

    // Gain FSM next state: enable changes direction at once, gain steps only on ticks.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        unique case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_RAMP_UP;
            end
            S_RAMP_UP: begin
                if (!enable) begin
                    state_d = S_RAMP_DOWN;
                end else if (tick) begin
                    if (({1'b0, gain_q} + 9'd1) >= {1'b0, GMAX}) begin
                        gain_d  = GMAX;
                        state_d = S_PLAY;
                    end else begin
                        gain_d = gain_q + 8'd1;
                    end
                end
            end
            S_PLAY: begin
                gain_d = GMAX;
                if (!enable) state_d = S_RAMP_DOWN;
            end
            S_RAMP_DOWN: begin
                if (enable) begin
                    state_d = S_RAMP_UP;
                end else if (tick) begin
                    if (gain_q <= 8'd1) begin
                        gain_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        gain_d = gain_q - 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sample period counter, parked at zero while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == S_IDLE || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // One-entry hold buffer, current sample and underrun accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            cur_sample_q <= '0;
            underrun_q   <= '0;
        end else if (clr) begin
            hold_full_q  <= 1'b0;
            cur_sample_q <= '0;
            underrun_q   <= '0;
        end else begin
            // Accept needs an empty hold, so it never collides with the tick's unload.
            if (tick) begin
                if (hold_full_q) begin
                    cur_sample_q <= hold_q;
                    hold_full_q  <= 1'b0;
                end else if (underrun_q != 8'hFF) begin
                    underrun_q <= underrun_q + 8'd1;
                end
            end
            if (accept) begin
                hold_q      <= in_if.in_sample;
                hold_full_q <= 1'b1;
            end
        end
    end

    // Gain scaling pipeline stage; gain of 128 is exact passthrough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scaled_q <= '0;
        end else begin
            scaled_q <= 16'(prod >>> 7);
        end
    end

    // First-order delta-sigma: the accumulator carry is the output bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            audio_q <= 1'b0;
        end else if (clr) begin
            acc_q   <= '0;
            audio_q <= 1'b0;
        end else begin
            acc_q   <= sum[15:0];
            audio_q <= sum[16];
        end
    end

endmodule
